// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//   Shared definitions for the memory-stage controller of the five-stage
//   RV32I pipeline: load/store funct3 encodings, the access-size decode and
//   the controller state encoding.
//
//   Contents:
//     F3_B/F3_H/F3_W/F3_BU/F3_HU : funct3 encodings for loads and stores
//     state_e                    : IDLE / BUSY / DONE (2-bit)
//     size_e                     : byte / half / word access size
//     decode_size()              : funct3 -> access size (unknown codes = word)
//     is_misaligned()            : size + byte lane -> misalignment flag
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  // Reserved encodings (011, 110, 111) fall through to a full-word access.
  function automatic size_e decode_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SIZE_B;
      F3_H, F3_HU: return SIZE_H;
      F3_W:        return SIZE_W;
      default:     return SIZE_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
    case (size)
      SIZE_H:  return lane[0];
      SIZE_W:  return |lane;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// -----------------------------------------------------------------------------
// load_store_align
//   Purely combinational byte-lane steering for RV32I loads and stores.
//
//   Store side: access size + lane -> byte enables and lane-replicated data.
//   Load side : access size + lane + memory word -> sign/zero-extended data.
//   Low address bits below the access size are ignored (a halfword uses only
//   lane[1], a word ignores the lane entirely).
//
//   Ports:
//     funct3     in   3  load/store size and sign encoding
//     lane       in   2  byte address bits [1:0]
//     store_data in  32  rs2 store data
//     rdata      in  32  word returned by memory
//     be         out  4  byte enables for the store
//     wdata      out 32  replicated store data
//     load_data  out 32  extended load result
// -----------------------------------------------------------------------------
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  size_e       size;
  logic        sign_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign size     = decode_size(funct3);
  // funct3[2] distinguishes the unsigned variants (LBU/LHU).
  assign sign_ext = ~funct3[2];

  // Store steering: replication lets memory pick any lane with be alone.
  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (size)
      SIZE_B: begin
        be    = 4'b0001 << lane;
        wdata = {4{store_data[7:0]}};
      end
      SIZE_H: begin
        be    = 4'b0011 << {lane[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Load steering and extension.
  always_comb begin
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_B:  load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SIZE_H:  load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//   Memory-stage controller between the EX/MEM and MEM/WB pipeline registers.
//   Issues one access per load/store on a variable-latency req/ack data port,
//   aligns store data, extends load data and stalls the upstream pipeline
//   (PC, IF/ID, ID/EX, EX/MEM) until the access completes.
//
//   Sequence: IDLE (request registered) -> BUSY (wait for mem_ack) -> DONE.
//   StallM drops only in DONE, so MEM/WB captures ReadDataM exactly once.
//
//   Optional build macro: MEM_MISALIGN_CHECK_EN
//     Adds output MisalignM. A misaligned half/word access then issues no
//     request, does not stall, and clears ReadDataM.
//
//   Ports:
//     clk, rst      clock (rising edge), async active-high reset
//     MemReadM      load in MEM stage
//     MemWriteM     store in MEM stage (wins if both are set)
//     Funct3M       size / sign encoding
//     ALUResultM    byte address
//     WriteDataM    store data (rs2)
//     ReadDataM     registered, extended load data to MEM/WB
//     StallM        combinational freeze of upstream stages
//     mem_req/we/addr/be/wdata  registered memory request
//     mem_rdata     memory read word, valid with mem_ack
//     mem_ack       one-cycle completion pulse
//     MisalignM     (MEM_MISALIGN_CHECK_EN only) misaligned pending access
// -----------------------------------------------------------------------------
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic              MisalignM
`endif
);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;

  logic              access_pending;
  logic              misaligned;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] ld_data;

  assign access_pending = MemReadM | MemWriteM;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = access_pending &
                      is_misaligned(decode_size(Funct3M), ALUResultM[1:0]);
  assign MisalignM  = misaligned;
`else
  assign misaligned = 1'b0;
`endif

  load_store_align u_align (
    .funct3     (Funct3M),
    .lane       (ALUResultM[1:0]),
    .store_data (WriteDataM),
    .rdata      (mem_rdata),
    .be         (st_be),
    .wdata      (st_wdata),
    .load_data  (ld_data)
  );

  // Releasing the stall in DONE is what lets the pipeline advance exactly
  // one instruction per completed access.
  assign StallM = access_pending & ~misaligned & (state_q != DONE);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    read_data_d = read_data_q;

    case (state_q)
      IDLE: begin
        if (access_pending && !misaligned) begin
          mem_req_d   = 1'b1;
          mem_we_d    = MemWriteM;
          mem_addr_d  = {ALUResultM[ADDR_W-1:2], 2'b00};
          mem_be_d    = st_be;
          mem_wdata_d = st_wdata;
          state_d     = BUSY;
        end else if (misaligned) begin
          // Rejected access still retires through MEM/WB with a zero result.
          read_data_d = '0;
        end
      end
      BUSY: begin
        // Inputs are held stable by the stall, so the lane/size used for
        // extension here are those of the access that was issued.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          if (!mem_we_q) begin
            read_data_d = ld_data;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      read_data_q <= read_data_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign ReadDataM = read_data_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
//   Self-checking bench for mem_stage_ctrl. A byte-addressed reference memory
//   predicts each request and each load result; a word-addressed responder
//   memory models the data port and is only updated by what the DUT writes.
//   Define MEM_MISALIGN_CHECK_EN to exercise the misalignment option.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage_ctrl;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        resp_ack, spur_ack;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        MisalignM;
`endif

  assign mem_ack = resp_ack | spur_ack;

  mem_stage_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .MisalignM  (MisalignM)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model (byte-addressed) ----------------
  logic [7:0]  ref_mem  [int unsigned];
  logic [31:0] resp_mem [int unsigned];

  function automatic logic [7:0] init_byte(input int unsigned a);
    logic [31:0] h;
    logic [31:0] av;
    av = a;
    h  = av * 32'h9E37_79B1;
    return h[23:16] ^ av[7:0];
  endfunction

  function automatic logic [7:0] ref_rd(input int unsigned a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [31:0] resp_word(input int unsigned wa);
    if (resp_mem.exists(wa)) return resp_mem[wa];
    return {init_byte(wa + 3), init_byte(wa + 2), init_byte(wa + 1), init_byte(wa)};
  endfunction

  function automatic int size_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_mis(input int sz, input logic [31:0] addr);
`ifdef MEM_MISALIGN_CHECK_EN
    return (addr % sz) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] data);
    for (int k = 0; k < 4; k++) ref_mem[wa + k] = data[8*k +: 8];
    resp_mem[wa] = data;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        is_load;
    logic        mis;
    logic [31:0] rdata;
    int          stall;
  } cmp_t;

  req_t req_q[$];
  cmp_t cmp_q[$];
  int   lat_q[$];

  bit resp_en = 1'b0;
  bit mon_en  = 1'b0;

  // Predict, then present one instruction to MEM and hold it until released.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int lat);
    req_t        r;
    cmp_t        c;
    int          sz;
    int unsigned ea;
    int unsigned ba;
    logic [31:0] v;
    bit          stalled;
    int          n;
    sz        = size_bytes(f3);
    c.is_load = rd & ~wr;
    c.mis     = 1'b0;
    c.rdata   = '0;
    c.stall   = 0;
    if (rd | wr) begin
      if (is_mis(sz, addr)) begin
        c.mis     = 1'b1;
        c.is_load = 1'b0;
        cmp_q.push_back(c);
      end else begin
        ea      = addr & ~(sz - 1);
        r.addr  = {addr[31:2], 2'b00};
        r.we    = wr;
        r.be    = 4'b0000;
        r.wdata = '0;
        for (int i = 0; i < 4; i++) begin
          ba = r.addr + i;
          if (ba >= ea && ba < ea + sz) r.be[i] = 1'b1;
          r.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
        end
        if (wr) begin
          for (int k = 0; k < sz; k++) ref_mem[ea + k] = wd[8*k +: 8];
        end else begin
          v = '0;
          for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_rd(ea + k);
          if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | ~((32'h1 << (8*sz)) - 1);
          c.rdata = v;
        end
        c.stall = 2 + lat;
        req_q.push_back(r);
        lat_q.push_back(lat);
        cmp_q.push_back(c);
      end
    end
    MemReadM   = rd;
    MemWriteM  = wr;
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    n = 0;
    do begin
      @(negedge clk);
      stalled = StallM;
      @(posedge clk);
      #1;
      n++;
    end while (stalled && n < 64);
    if (stalled) fail_now("issue_timeout");
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    int          lat;
    logic [31:0] w;
    resp_ack  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en && mem_req && !rst) begin
        lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        repeat (lat) begin
          @(posedge clk);
          #1;
        end
        w = resp_word(mem_addr);
        if (mem_we) begin
          for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
          resp_mem[mem_addr] = w;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = w;
        end
        resp_ack = 1'b1;
        @(posedge clk);
        #1;
        resp_ack  = 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    req_t        cur;
    cmp_t        c;
    bit          req_prev;
    int          stall_cnt;
    logic [31:0] last_read;
    bit          zero_next;
    req_prev  = 1'b0;
    stall_cnt = 0;
    last_read = '0;
    zero_next = 1'b0;
    cur       = '{addr: '0, we: 1'b0, be: 4'b0000, wdata: '0};
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (zero_next) begin
          check("misalign_rdata_zero", ReadDataM, 32'h0);
          zero_next = 1'b0;
        end
        if (mem_req && !req_prev) begin
          if (req_q.size() == 0) begin
            fail_now("unexpected_req");
          end else begin
            cur = req_q.pop_front();
            check("req_addr", mem_addr, cur.addr);
            check("req_we", mem_we, cur.we);
            if (cur.we) begin
              check("req_be", mem_be, cur.be);
              check("req_wdata", mem_wdata, cur.wdata);
            end
          end
        end else if (mem_req) begin
          check("hold_addr", mem_addr, cur.addr);
          check("hold_we", mem_we, cur.we);
          if (cur.we) begin
            check("hold_be", mem_be, cur.be);
            check("hold_wdata", mem_wdata, cur.wdata);
          end
        end
        req_prev = mem_req;
        if (MemReadM | MemWriteM) begin
          if (StallM) begin
            stall_cnt++;
          end else if (cmp_q.size() == 0) begin
            fail_now("unexpected_completion");
            stall_cnt = 0;
          end else begin
            c = cmp_q.pop_front();
            check("stall_cycles", stall_cnt, c.stall);
            if (c.is_load) begin
              check("load_data", ReadDataM, c.rdata);
              last_read = c.rdata;
            end else begin
              check("read_data_hold", ReadDataM, last_read);
            end
`ifdef MEM_MISALIGN_CHECK_EN
            check("misalign_flag", MisalignM, c.mis);
`endif
            if (c.mis) begin
              last_read = '0;
              zero_next = 1'b1;
            end
            stall_cnt = 0;
          end
        end else begin
          check("idle_stall", StallM, 1'b0);
          check("idle_req", mem_req, 1'b0);
          check("idle_read_hold", ReadDataM, last_read);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int          kind;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    rst        = 1'b1;
    spur_ack   = 1'b0;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    Funct3M    = 3'b000;
    ALUResultM = '0;
    WriteDataM = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", mem_be, 4'b0000);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_read_data", ReadDataM, 32'h0);
    check("rst_stall", StallM, 1'b0);
    #2 rst = 1'b0;

    // Reset while an access is outstanding.
    @(posedge clk);
    #1;
    MemReadM   = 1'b1;
    Funct3M    = F3_W;
    ALUResultM = 32'h40;
    @(negedge clk);
    check("idle_pending_stall", StallM, 1'b1);
    @(posedge clk);
    #1;
    check("busy_req", mem_req, 1'b1);
    check("busy_addr", mem_addr, 32'h40);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midbusy_rst_req", mem_req, 1'b0);
    check("midbusy_rst_addr", mem_addr, 32'h0);
    check("midbusy_rst_be", mem_be, 4'b0000);
    check("midbusy_rst_read", ReadDataM, 32'h0);
    MemReadM = 1'b0;
    #1;
    check("midbusy_rst_stall", StallM, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    spur_ack = 1'b1;
    @(posedge clk);
    #1;
    spur_ack = 1'b0;
    @(negedge clk);
    check("spur_ack_req", mem_req, 1'b0);
    check("spur_ack_stall", StallM, 1'b0);
    check("spur_ack_read", ReadDataM, 32'h0);
    @(posedge clk);
    #1;
    mon_en  = 1'b1;
    resp_en = 1'b1;

    // Directed cases.
    preload(32'h100, 32'h80FF_FFFF);
    issue(1'b1, 1'b0, F3_B, 32'h103, 32'h0, 2);
    preload(32'h200, 32'hBEEF_1234);
    issue(1'b1, 1'b0, F3_HU, 32'h202, 32'h0, 0);
    issue(1'b0, 1'b1, F3_B, 32'h7, 32'h1234_56AB, 1);
    issue(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 0);
    issue(1'b0, 1'b1, F3_W, 32'h10, 32'hCAFE_F00D, 0);
    issue(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1);
    issue(1'b1, 1'b1, F3_H, 32'h12, 32'h0000_5A5A, 0);
    issue(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 0);
    issue(1'b1, 1'b0, F3_H, 32'h11, 32'h0, 0);
    issue(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    issue(1'b1, 1'b0, F3_W, 32'h6, 32'h0, 0);
    issue(1'b0, 1'b1, F3_H, 32'h21, 32'hFFFF_FFFF, 0);
    issue(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 0);
`endif

    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      a    = $urandom_range(0, 63);
      wd   = $urandom;
      lat  = $urandom_range(0, 3);
      if (kind < 2) begin
        issue(1'b0, 1'b0, 3'($urandom_range(0, 7)), a, wd, 0);
      end else if (kind < 6) begin
        f3 = 3'($urandom_range(0, 7));
        issue(1'b1, 1'b0, f3, a, wd, lat);
      end else if (kind < 9) begin
        f3 = 3'($urandom_range(0, 2));
        issue(1'b0, 1'b1, f3, a, wd, lat);
      end else begin
        f3 = 3'($urandom_range(0, 2));
        issue(1'b1, 1'b1, f3, a, wd, lat);
      end
    end

    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("req_queue_drained", req_q.size(), 32'h0);
    check("cmp_queue_drained", cmp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
